foc_ctrl_seq: RTL and testbench

FOC_CTRL_SEQ -- requirements
Module: foc_ctrl_seq

---
 rtl/foc_ctrl_seq_if.sv | 30 +++
 rtl/foc_ctrl_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_foc_ctrl_seq.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/foc_ctrl_seq_if.sv
// Sequencer-to-FOC-core bundle: PID coefficient write port plus sample handshake.
// Handshake: valid is held high for VALID_HOLD cycles with stable data; the core
// acknowledges completion with a rising edge on ready, which only counts while the sequencer waits.
interface foc_ctrl_seq_if #(
  parameter int D_WIDTH = 19
);
  logic               pid_d_wen;
  logic               pid_q_wen;
  logic [D_WIDTH-1:0] pid_d_addr;
  logic [D_WIDTH-1:0] pid_q_addr;
  logic [D_WIDTH-1:0] pid_d_data;
  logic [D_WIDTH-1:0] pid_q_data;
  logic               valid;
  logic [D_WIDTH-1:0] angle_in;
  logic [D_WIDTH-1:0] currA_in;
  logic [D_WIDTH-1:0] currB_in;
  logic               ready;

  modport master (
    output pid_d_wen, pid_q_wen, pid_d_addr, pid_q_addr, pid_d_data, pid_q_data,
    output valid, angle_in, currA_in, currB_in,
    input  ready
  );

  modport slave (
    input  pid_d_wen, pid_q_wen, pid_d_addr, pid_q_addr, pid_d_data, pid_q_data,
    input  valid, angle_in, currA_in, currB_in,
    output ready
  );
endinterface

// File: rtl/foc_ctrl_seq.sv
// FOC control sequencer: programs PID coefficients, then issues ADC/resolver samples
// to the core with a one-deep pending buffer, ready-edge completion and a WAIT timeout.
module foc_ctrl_seq #(
  parameter int D_WIDTH     = 19,
  parameter int VALID_HOLD  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic [D_WIDTH-1:0] cfg_kp_d,
  input  logic [D_WIDTH-1:0] cfg_ki_d,
  input  logic [D_WIDTH-1:0] cfg_kp_q,
  input  logic [D_WIDTH-1:0] cfg_ki_q,
  input  logic               sample_strobe,
  input  logic [D_WIDTH-1:0] angle_s,
  input  logic [D_WIDTH-1:0] currA_s,
  input  logic [D_WIDTH-1:0] currB_s,
  input  logic               fault_clr,
  output logic               busy,
  output logic               cfg_done,
  output logic               overrun,
  output logic               fault,
  output logic [2:0]         state_o,
  foc_ctrl_seq_if.master     core
);

  localparam int HW = $clog2(VALID_HOLD + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(VALID_HOLD - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CFG_KP  = 3'd1,
    S_CFG_KI  = 3'd2,
    S_CFG_END = 3'd3,
    S_ARMED   = 3'd4,
    S_ISSUE   = 3'd5,
    S_WAIT    = 3'd6,
    S_FAULT   = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [TW-1:0]      to_q, to_d;
  logic               ready_q;
  logic               pend_q, pend_d;
  logic [D_WIDTH-1:0] pend_angle_q, pend_angle_d;
  logic [D_WIDTH-1:0] pend_ia_q, pend_ia_d;
  logic [D_WIDTH-1:0] pend_ib_q, pend_ib_d;
  logic [D_WIDTH-1:0] angle_q, angle_d;
  logic [D_WIDTH-1:0] ia_q, ia_d;
  logic [D_WIDTH-1:0] ib_q, ib_d;
  logic               cfg_req_q, cfg_req_d;
  logic               cfg_done_q, cfg_done_d;
  logic               overrun_q, overrun_d;
  logic               store_ok;
  logic               cfg_go;
  logic               ready_rise;

  assign ready_rise = core.ready & ~ready_q;
  assign cfg_go     = cfg_start | cfg_req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q       <= '0;
      to_q         <= '0;
      ready_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_angle_q <= '0;
      pend_ia_q    <= '0;
      pend_ib_q    <= '0;
      angle_q      <= '0;
      ia_q         <= '0;
      ib_q         <= '0;
      cfg_req_q    <= 1'b0;
      cfg_done_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      to_q         <= to_d;
      ready_q      <= core.ready;
      pend_q       <= pend_d;
      pend_angle_q <= pend_angle_d;
      pend_ia_q    <= pend_ia_d;
      pend_ib_q    <= pend_ib_d;
      angle_q      <= angle_d;
      ia_q         <= ia_d;
      ib_q         <= ib_d;
      cfg_req_q    <= cfg_req_d;
      cfg_done_q   <= cfg_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Counters default to zero so each is cleared on entry to its state.
  always_comb begin
    state_d      = state_q;
    hold_d       = '0;
    to_d         = '0;
    pend_d       = pend_q;
    pend_angle_d = pend_angle_q;
    pend_ia_d    = pend_ia_q;
    pend_ib_d    = pend_ib_q;
    angle_d      = angle_q;
    ia_d         = ia_q;
    ib_d         = ib_q;
    cfg_req_d    = cfg_req_q;
    cfg_done_d   = cfg_done_q;
    overrun_d    = overrun_q;
    store_ok     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_go) state_d = S_CFG_KP;
      end
      S_CFG_KP: begin
        store_ok = 1'b1;
        state_d  = S_CFG_KI;
      end
      S_CFG_KI: begin
        store_ok = 1'b1;
        state_d  = S_CFG_END;
      end
      S_CFG_END: begin
        store_ok   = 1'b1;
        cfg_done_d = 1'b1;
        state_d    = S_ARMED;
      end
      S_ARMED: begin
        if (cfg_go) begin
          store_ok = 1'b1;
          state_d  = S_CFG_KP;
        end else if (pend_q) begin
          // Pending slot is freed here, so a same-cycle strobe refills it without overrun.
          store_ok = 1'b1;
          pend_d   = 1'b0;
          angle_d  = pend_angle_q;
          ia_d     = pend_ia_q;
          ib_d     = pend_ib_q;
          state_d  = S_ISSUE;
        end else if (sample_strobe) begin
          angle_d = angle_s;
          ia_d    = currA_s;
          ib_d    = currB_s;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        store_ok = 1'b1;
        if (hold_q == HOLD_LAST) state_d = S_WAIT;
        else                     hold_d  = hold_q + 1'b1;
      end
      S_WAIT: begin
        store_ok = 1'b1;
        if (ready_rise)          state_d = S_ARMED;
        else if (to_q == TO_LAST) state_d = S_FAULT;
        else                     to_d    = to_q + 1'b1;
      end
      S_FAULT: begin
        pend_d = 1'b0;
        if (fault_clr) state_d = cfg_done_q ? S_ARMED : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (store_ok && sample_strobe) begin
      if (pend_d) overrun_d = 1'b1;
      pend_d       = 1'b1;
      pend_angle_d = angle_s;
      pend_ia_d    = currA_s;
      pend_ib_d    = currB_s;
    end

    if (state_q inside {S_IDLE, S_ARMED}) begin
      if (state_d == S_CFG_KP) cfg_req_d = 1'b0;
    end else if (cfg_start) begin
      cfg_req_d = 1'b1;
    end

    if (fault_clr) overrun_d = 1'b0;
  end

  always_comb begin
    core.valid      = (state_q == S_ISSUE);
    core.pid_d_wen  = 1'b0;
    core.pid_q_wen  = 1'b0;
    core.pid_d_addr = '0;
    core.pid_q_addr = '0;
    core.pid_d_data = '0;
    core.pid_q_data = '0;
    case (state_q)
      S_CFG_KP: begin
        core.pid_d_wen  = 1'b1;
        core.pid_q_wen  = 1'b1;
        core.pid_d_data = cfg_kp_d;
        core.pid_q_data = cfg_kp_q;
      end
      S_CFG_KI: begin
        core.pid_d_wen  = 1'b1;
        core.pid_q_wen  = 1'b1;
        core.pid_d_addr = D_WIDTH'(1);
        core.pid_q_addr = D_WIDTH'(1);
        core.pid_d_data = cfg_ki_d;
        core.pid_q_data = cfg_ki_q;
      end
      default: ;
    endcase
    busy     = !(state_q inside {S_IDLE, S_ARMED, S_FAULT});
    fault    = (state_q == S_FAULT);
    cfg_done = cfg_done_q | (state_q == S_CFG_END);
  end

  assign core.angle_in = angle_q;
  assign core.currA_in = ia_q;
  assign core.currB_in = ib_q;
  assign overrun       = overrun_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_foc_ctrl_seq.sv
// Directed bench for foc_ctrl_seq: scoreboard queues for issued samples and
// coefficient writes, plus step-by-step state and status checks.
module tb_foc_ctrl_seq;
  localparam int DW = 19;
  localparam int VH = 4;
  localparam int TO = 16;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_CFG_KP = 3'd1, ST_CFG_KI = 3'd2, ST_CFG_END = 3'd3;
  localparam logic [2:0] ST_ARMED = 3'd4, ST_ISSUE = 3'd5, ST_WAIT = 3'd6, ST_FAULT = 3'd7;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start, sample_strobe, fault_clr;
  logic [DW-1:0] cfg_kp_d, cfg_ki_d, cfg_kp_q, cfg_ki_q;
  logic [DW-1:0] angle_s, currA_s, currB_s;
  logic          busy, cfg_done, overrun, fault;
  logic [2:0]    dut_state;

  foc_ctrl_seq_if #(.D_WIDTH(DW)) core_if ();

  foc_ctrl_seq #(.D_WIDTH(DW), .VALID_HOLD(VH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start),
    .cfg_kp_d(cfg_kp_d), .cfg_ki_d(cfg_ki_d), .cfg_kp_q(cfg_kp_q), .cfg_ki_q(cfg_ki_q),
    .sample_strobe(sample_strobe), .angle_s(angle_s), .currA_s(currA_s), .currB_s(currB_s),
    .fault_clr(fault_clr), .busy(busy), .cfg_done(cfg_done), .overrun(overrun),
    .fault(fault), .state_o(dut_state), .core(core_if)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [3*DW-1:0] exp_q[$];
  logic [2*DW:0]   wr_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag);
    int n = 0;
    while (dut_state !== tgt && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(dut_state), 32'(tgt));
  endtask

  task automatic drive_sample(input logic [DW-1:0] a, input logic [DW-1:0] ia, input logic [DW-1:0] ib);
    angle_s = a;
    currA_s = ia;
    currB_s = ib;
  endtask

  task automatic strobe_expect(input logic [DW-1:0] a, input logic [DW-1:0] ia, input logic [DW-1:0] ib);
    drive_sample(a, ia, ib);
    exp_q.push_back({a, ia, ib});
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
  endtask

  task automatic ready_pulse();
    core_if.ready = 1'b1;
    tick();
    core_if.ready = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom_range(0, (1 << DW) - 1));
  endfunction

  // Sample monitor: pop on each valid rise, check data every valid cycle and the run length.
  initial begin
    logic [3*DW-1:0] cur;
    logic            vld_prev;
    int              vld_len;
    cur = '0;
    vld_prev = 1'b0;
    vld_len = 0;
    forever begin
      @(negedge clk);
      if (core_if.valid === 1'b1) begin
        if (!vld_prev) begin
          chk("sample_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) cur = exp_q.pop_front();
          vld_len = 0;
        end
        chk("angle_in", 32'(core_if.angle_in), 32'(cur[3*DW-1:2*DW]));
        chk("currA_in", 32'(core_if.currA_in), 32'(cur[2*DW-1:DW]));
        chk("currB_in", 32'(core_if.currB_in), 32'(cur[DW-1:0]));
        vld_len++;
      end else if (vld_prev) begin
        chk("valid_len", 32'(vld_len), 32'(VH));
      end
      vld_prev = (core_if.valid === 1'b1);
    end
  end

  // Coefficient write monitor.
  initial begin
    logic [2*DW:0] w;
    forever begin
      @(negedge clk);
      if (core_if.pid_d_wen === 1'b1 || core_if.pid_q_wen === 1'b1) begin
        chk("wr_expected", 32'(wr_q.size() > 0), 32'd1);
        w = (wr_q.size() > 0) ? wr_q.pop_front() : '0;
        chk("wen_pair", 32'({core_if.pid_d_wen, core_if.pid_q_wen}), 32'd3);
        chk("pid_d_addr", 32'(core_if.pid_d_addr), 32'(w[2*DW]));
        chk("pid_q_addr", 32'(core_if.pid_q_addr), 32'(w[2*DW]));
        chk("pid_d_data", 32'(core_if.pid_d_data), 32'(w[2*DW-1:DW]));
        chk("pid_q_data", 32'(core_if.pid_q_data), 32'(w[DW-1:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] kpd, kid, kpq, kiq;
    rst = 1'b1;
    cfg_start = 1'b0;
    sample_strobe = 1'b0;
    fault_clr = 1'b0;
    cfg_kp_d = '0; cfg_ki_d = '0; cfg_kp_q = '0; cfg_ki_q = '0;
    drive_sample('0, '0, '0);
    core_if.ready = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(dut_state), 32'(ST_IDLE));
    chk("rst_valid", 32'(core_if.valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_done", 32'(cfg_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_wen", 32'(core_if.pid_d_wen), 32'd0);
    rst = 1'b0;
    tick();

    // Strobe in IDLE is ignored.
    drive_sample(rnd(), rnd(), rnd());
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    tick();
    tick();
    chk("idle_strobe_state", 32'(dut_state), 32'(ST_IDLE));
    chk("idle_strobe_valid", 32'(core_if.valid), 32'd0);

    // Coefficient programming.
    cfg_kp_d = DW'(4096); cfg_kp_q = DW'(4096);
    cfg_ki_d = DW'(512);  cfg_ki_q = DW'(512);
    wr_q.push_back({1'b0, DW'(4096), DW'(4096)});
    wr_q.push_back({1'b1, DW'(512), DW'(512)});
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("cfg_kp_state", 32'(dut_state), 32'(ST_CFG_KP));
    chk("cfg_kp_busy", 32'(busy), 32'd1);
    chk("cfg_kp_done", 32'(cfg_done), 32'd0);
    tick();
    chk("cfg_ki_state", 32'(dut_state), 32'(ST_CFG_KI));
    tick();
    chk("cfg_end_done", 32'(cfg_done), 32'd1);
    chk("cfg_end_wen", 32'(core_if.pid_d_wen), 32'd0);
    tick();
    chk("cfg_armed", 32'(dut_state), 32'(ST_ARMED));
    chk("cfg_armed_busy", 32'(busy), 32'd0);

    // Basic sample issue.
    strobe_expect(DW'(19'h1FFF), DW'(16384), rnd());
    chk("issue_valid_first", 32'(core_if.valid), 32'd1);
    chk("issue_state", 32'(dut_state), 32'(ST_ISSUE));
    repeat (VH - 1) tick();
    chk("issue_valid_last", 32'(core_if.valid), 32'd1);
    tick();
    chk("issue_done_valid", 32'(core_if.valid), 32'd0);
    chk("issue_wait_state", 32'(dut_state), 32'(ST_WAIT));
    ready_pulse();
    chk("ready_armed", 32'(dut_state), 32'(ST_ARMED));
    chk("ready_busy", 32'(busy), 32'd0);

    // Overrun: two strobes while waiting, second one wins.
    strobe_expect(rnd(), rnd(), rnd());
    wait_state(ST_WAIT, 20, "ovr_reach_wait");
    drive_sample(rnd(), rnd(), rnd());
    sample_strobe = 1'b1;
    tick();
    chk("ovr_single_pending", 32'(overrun), 32'd0);
    strobe_expect(rnd(), rnd(), rnd());
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_still_wait", 32'(dut_state), 32'(ST_WAIT));
    ready_pulse();
    chk("ovr_armed", 32'(dut_state), 32'(ST_ARMED));
    tick();
    chk("ovr_issue", 32'(dut_state), 32'(ST_ISSUE));
    wait_state(ST_WAIT, 20, "ovr_second_wait");
    ready_pulse();
    chk("ovr_back_armed", 32'(dut_state), 32'(ST_ARMED));

    // Timeout into FAULT with ready held low.
    strobe_expect(rnd(), rnd(), rnd());
    wait_state(ST_WAIT, 20, "to_reach_wait");
    repeat (TO - 2) tick();
    chk("to_wait_15", 32'(dut_state), 32'(ST_WAIT));
    tick();
    chk("to_wait_16", 32'(dut_state), 32'(ST_WAIT));
    tick();
    chk("to_fault_state", 32'(dut_state), 32'(ST_FAULT));
    chk("to_fault_flag", 32'(fault), 32'd1);
    chk("to_fault_valid", 32'(core_if.valid), 32'd0);
    chk("to_fault_busy", 32'(busy), 32'd0);
    chk("to_overrun_sticky", 32'(overrun), 32'd1);
    drive_sample(rnd(), rnd(), rnd());
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_armed", 32'(dut_state), 32'(ST_ARMED));
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_overrun", 32'(overrun), 32'd0);
    tick();
    tick();
    chk("fault_strobe_dropped", 32'(dut_state), 32'(ST_ARMED));

    // Collision: cfg_start and strobe together in ARMED.
    kpd = rnd(); kid = rnd(); kpq = rnd(); kiq = rnd();
    cfg_kp_d = kpd; cfg_ki_d = kid; cfg_kp_q = kpq; cfg_ki_q = kiq;
    wr_q.push_back({1'b0, kpd, kpq});
    wr_q.push_back({1'b1, kid, kiq});
    cfg_start = 1'b1;
    strobe_expect(rnd(), rnd(), rnd());
    cfg_start = 1'b0;
    chk("col_cfg_first", 32'(dut_state), 32'(ST_CFG_KP));
    chk("col_valid_low", 32'(core_if.valid), 32'd0);
    tick();
    tick();
    tick();
    chk("col_armed", 32'(dut_state), 32'(ST_ARMED));
    tick();
    chk("col_issue", 32'(dut_state), 32'(ST_ISSUE));
    chk("col_valid", 32'(core_if.valid), 32'd1);
    wait_state(ST_WAIT, 20, "col_wait");
    ready_pulse();
    chk("col_back_armed", 32'(dut_state), 32'(ST_ARMED));

    // Asynchronous reset in WAIT.
    strobe_expect(rnd(), rnd(), rnd());
    wait_state(ST_WAIT, 20, "rst_reach_wait");
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(dut_state), 32'(ST_IDLE));
    chk("async_rst_valid", 32'(core_if.valid), 32'd0);
    chk("async_rst_cfg_done", 32'(cfg_done), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    drive_sample(rnd(), rnd(), rnd());
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    repeat (6) tick();
    chk("post_rst_idle", 32'(dut_state), 32'(ST_IDLE));
    chk("post_rst_no_valid", 32'(core_if.valid), 32'd0);
    chk("post_rst_no_wen", 32'(core_if.pid_d_wen), 32'd0);
    chk("post_rst_angle", 32'(core_if.angle_in), 32'd0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
